avs_hram_pattern_tester: RTL and testbench

//  Avalon-MM master traffic generator that sits directly upstream of avs_hram_converter.
//  On a start request from the board switches it writes a pattern to a HyperRAM window.
//  It then reads the window back and compares every word against the pattern.

---
 rtl/avs_hram_pattern_tester.sv | 118 +++++++++++
 tb/tb_avs_hram_pattern_tester.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/avs_hram_pattern_tester.sv
// avs_hram_pattern_tester: Avalon-MM pattern write/readback tester for a HyperRAM window
module avs_hram_pattern_tester #(
  parameter int ADDR_W    = 22,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        switches,
  output logic [3:0]        leds,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr
);
  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, DONE} state_t;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  function automatic logic [15:0] pattern(input logic [1:0] s, input logic [ADDR_W-1:0] i);
    logic [ADDR_W-1:0] a;
    a = BASE + i;
    return s == 2'b00 ? 16'(a) : s == 2'b01 ? ~16'(a) :
           s == 2'b10 ? (i[0] ? 16'h5555 : 16'hAAAA) : 16'h0001 << i[3:0];
  endfunction
  state_t            state;
  logic [2:0]        sw_s1, sw_s2;
  logic              start_q, start, last, mismatch, unused_sw;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] index, index_inc;
  logic [7:0]        err_next;
  assign unused_sw      = switches[3];
  assign avm_byteenable = 2'b11;
  assign start          = sw_s2[0] & ~start_q;
  assign last           = index == LAST;
  assign index_inc      = index + 1'b1;
  assign mismatch       = avm_readdata != pattern(sel, index);
  assign err_next       = mismatch && err_count != 8'hFF ? err_count + 8'd1 : err_count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      start_q <= 1'b0;
    end else begin
      sw_s1   <= switches[2:0];
      sw_s2   <= sw_s1;
      start_q <= sw_s2[0];
    end
  // Bus outputs and LEDs are registered: each transition loads the values for the next state.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state          <= IDLE;
      index          <= '0;
      sel            <= '0;
      leds           <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        IDLE, DONE:
          if (start) begin
            state          <= WR;
            index          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            sel            <= sw_s2[2:1];
            avm_write      <= 1'b1;
            avm_address    <= BASE;
            avm_writedata  <= pattern(sw_s2[2:1], '0);
            leds           <= 4'b0001;
          end
        WR:
          if (!avm_waitrequest) begin
            if (last) begin
              index     <= '0;
              avm_write <= 1'b0;
              state     <= RD;
              leds      <= 4'b1001;
            end else begin
              index         <= index_inc;
              avm_address   <= BASE + index_inc;
              avm_writedata <= pattern(sel, index_inc);
            end
          end
        // RD idles one cycle with read low, so no request follows a read-data return directly.
        RD:
          if (!avm_read) begin
            avm_read    <= 1'b1;
            avm_address <= BASE + index;
          end else if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= RWAIT;
          end
        RWAIT:
          if (avm_readdatavalid) begin
            err_count <= err_next;
            if (mismatch && err_count == 8'd0) first_err_addr <= BASE + index;
            if (last) begin
              state <= DONE;
              leds  <= {1'b0, err_next != 8'd0, err_next == 8'd0, 1'b0};
            end else begin
              index <= index_inc;
              state <= RD;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_avs_hram_pattern_tester.sv
// tb_avs_hram_pattern_tester: directed checks of the pattern tester against a simple Avalon slave model
module tb_avs_hram_pattern_tester;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [3:0]  switches = 4'b0000;
  logic [3:0]  leds;
  logic [21:0] avm_address, first_err_addr;
  logic        avm_read, avm_write, waitrequest;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic [15:0] rdata = 16'h0;
  logic        rvalid = 1'b0;
  logic [7:0]  err_count;
  logic [15:0] mem [256];
  int          wr_cnt [256];
  int          wr_total = 0, stalled = 0, stall_n = 0, total = 0, bad = 0;
  logic        unstable = 1'b0, both = 1'b0, corrupt = 1'b0, clr = 1'b0;
  logic [21:0] ref_addr = '0;
  logic [15:0] ref_data = '0;

  avs_hram_pattern_tester #(.ADDR_W(22), .BASE_ADDR(0), .NUM_WORDS(8)) dut (
    .clk(clk), .reset_n(reset_n), .switches(switches), .leds(leds),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(waitrequest), .avm_readdata(rdata), .avm_readdatavalid(rvalid),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  assign waitrequest = avm_write && avm_address == 22'd3 && stalled < stall_n;

  always @(posedge clk)
    if (clr) begin
      for (int i = 0; i < 256; i++) wr_cnt[i] <= 0;
      wr_total <= 0;
      stalled  <= 0;
      unstable <= 1'b0;
      rvalid   <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      if (avm_read && avm_write) both <= 1'b1;
      if (waitrequest) begin
        if (stalled == 0) begin
          ref_addr <= avm_address;
          ref_data <= avm_writedata;
        end else if (avm_address != ref_addr || avm_writedata != ref_data) unstable <= 1'b1;
        stalled <= stalled + 1;
      end
      if (avm_write && !waitrequest) begin
        mem[avm_address[7:0]]    <= avm_writedata;
        wr_cnt[avm_address[7:0]] <= wr_cnt[avm_address[7:0]] + 1;
        wr_total                 <= wr_total + 1;
      end
      if (avm_read && !waitrequest) begin
        rvalid <= 1'b1;
        rdata  <= corrupt && avm_address == 22'd5 ? 16'hDEAD : mem[avm_address[7:0]];
      end
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (leds[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 50), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(leds[1] | leds[2]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 500), 32'd1);
  endtask

  task automatic run(input logic [3:0] sw, input string tag);
    switches = {sw[3:1], 1'b0};
    repeat (3) @(negedge clk);
    switches = sw;
    wait_busy({tag, "_busy"});
    wait_done({tag, "_done"});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_write", 32'(avm_write), 32'h0);
    chk("rst_read", 32'(avm_read), 32'h0);
    chk("rst_be", 32'(avm_byteenable), 32'h3);
    chk("rst_err", 32'(err_count), 32'h0);
    chk("rst_first", 32'(first_err_addr), 32'h0);
    chk("rst_addr", 32'(avm_address), 32'h0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_noreq", 32'({avm_read, avm_write}), 32'h0);

    pulse_clr();
    run(4'b0001, "t2");
    chk("t2_leds", 32'(leds), 32'b0010);
    chk("t2_err", 32'(err_count), 32'h0);
    chk("t2_first", 32'(first_err_addr), 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_mem%0d", i), 32'(mem[i]), 32'(i));
      chk($sformatf("t2_wrcnt%0d", i), 32'(wr_cnt[i]), 32'd1);
    end

    pulse_clr();
    stall_n = 5;
    run(4'b0001, "t3");
    stall_n = 0;
    chk("t3_stall_cycles", 32'(stalled), 32'd5);
    chk("t3_stable", 32'(unstable), 32'h0);
    chk("t3_wrcnt3", 32'(wr_cnt[3]), 32'd1);
    chk("t3_wrtotal", 32'(wr_total), 32'd8);
    chk("t3_mem3", 32'(mem[3]), 32'd3);
    chk("t3_leds", 32'(leds), 32'b0010);

    pulse_clr();
    corrupt = 1'b1;
    run(4'b0011, "t4");
    corrupt = 1'b0;
    chk("t4_err", 32'(err_count), 32'd1);
    chk("t4_first", 32'(first_err_addr), 32'd5);
    chk("t4_leds", 32'(leds), 32'b0100);
    chk("t4_mem0", 32'(mem[0]), 32'hFFFF);
    chk("t4_mem5", 32'(mem[5]), 32'hFFFA);

    pulse_clr();
    run(4'b0101, "t5a");
    chk("t5a_err_cleared", 32'(err_count), 32'h0);
    chk("t5a_first_cleared", 32'(first_err_addr), 32'h0);
    chk("t5a_leds", 32'(leds), 32'b0010);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t5a_mem%0d", i), 32'(mem[i]), i % 2 == 1 ? 32'h5555 : 32'hAAAA);

    pulse_clr();
    run(4'b0111, "t5b");
    chk("t5b_leds", 32'(leds), 32'b0010);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t5b_mem%0d", i), 32'(mem[i]), 32'd1 << i);

    pulse_clr();
    switches = 4'b0000;
    repeat (3) @(negedge clk);
    switches = 4'b0001;
    wait_busy("t6_busy");
    for (int k = 0; k < 2; k++) begin
      switches = 4'b0110;
      repeat (3) @(negedge clk);
      switches = 4'b0111;
      repeat (3) @(negedge clk);
    end
    chk("t6_still_busy", 32'(leds[0]), 32'd1);
    wait_done("t6_done");
    chk("t6_one_run", 32'(wr_total), 32'd8);
    chk("t6_leds", 32'(leds), 32'b0010);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t6_sel_latched%0d", i), 32'(mem[i]), 32'(i));
    repeat (10) @(negedge clk);
    chk("t6_hold_leds", 32'(leds), 32'b0010);
    chk("t6_hold_wrtotal", 32'(wr_total), 32'd8);

    switches = 4'b0000;
    repeat (3) @(negedge clk);
    pulse_clr();
    switches = 4'b0001;
    repeat (4) @(negedge clk);
    switches = 4'b0000;
    wait_busy("t6g_busy");
    wait_done("t6g_done");
    repeat (40) @(negedge clk);
    chk("t6g_one_run", 32'(wr_total), 32'd8);
    chk("t6g_leds", 32'(leds), 32'b0010);

    switches = 4'b0000;
    repeat (3) @(negedge clk);
    switches = 4'b0001;
    wait_busy("t1_busy");
    chk("t1_pre_write", 32'(avm_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_write", 32'(avm_write), 32'h0);
    chk("t1_async_leds", 32'(leds), 32'h0);
    chk("t1_async_err", 32'(err_count), 32'h0);
    switches = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t1_idle_noreq", 32'({avm_read, avm_write}), 32'h0);
    chk("t1_idle_leds", 32'(leds), 32'h0);
    chk("no_rd_wr_overlap", 32'(both), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
